line_memory_responder: RTL and testbench

- Synthesizable responder for the 256-bit cache-line physical-memory protocol: read, write, address, wdata, resp and rdata.
- Sits at the memory end of the L2 / eviction-buffer / prefetcher chain and replaces the behavioural pmem for on-board runs and bench regressions.
- Backs an internal line array, models open-row latency (row hit vs row miss) and flags initiator protocol violations.

---
 rtl/line_memory_responder.sv | 128 ++++++++++++
 tb/tb_line_memory_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Cache-line memory responder: 256-bit line array behind a read/write handshake,
// with open-row latency modelling and a sticky initiator protocol-violation flag.
module line_memory_responder #(
   parameter int IDX_BITS = 12,
   parameter int ROW_BITS = 6,
   parameter int HIT_LAT  = 4,
   parameter int MISS_LAT = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         read,
   input  logic         write,
   input  logic [31:0]  address,
   input  logic [255:0] wdata,
   output logic         resp,
   output logic [255:0] rdata,
   output logic         busy,
   output logic         proto_err
);

   localparam int TAG_W = 27 - ROW_BITS;
   localparam int DEPTH = 1 << IDX_BITS;
   localparam logic [7:0] HIT_L  = 8'(HIT_LAT);
   localparam logic [7:0] MISS_L = 8'(MISS_LAT);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t             state;
   logic [7:0]         cnt;
   logic               op_wr;
   logic [26:0]        lat_line;
   logic [255:0]       lat_data;
   logic [TAG_W-1:0]   open_row;
   logic               row_valid;
   logic [255:0]       mem [DEPTH];

   logic [26:0]         in_line;
   logic [TAG_W-1:0]    in_tag;
   logic [TAG_W-1:0]    lat_tag;
   logic [7:0]          lat;
   logic                accept;
   logic                clash;
   logic                fast;
   logic                finish;
   logic                go_resp;
   logic                go_wr;
   logic [IDX_BITS-1:0] go_idx;
   logic [255:0]        go_data;
   logic [TAG_W-1:0]    go_tag;
   logic                mism;
   logic                violate;
   logic                unused_bits;

   assign unused_bits = ^address[4:0];

   assign in_line = address[31:5];
   assign in_tag  = address[31:5+ROW_BITS];
   assign lat_tag = lat_line[26:ROW_BITS];
   assign lat     = (row_valid && in_tag == open_row) ? HIT_L : MISS_L;

   assign accept = (state == IDLE) && (read ^ write);
   assign clash  = (state == IDLE) && read && write;
   assign fast   = accept && (lat == 8'd1);
   assign finish = (state == BUSY) && (cnt == 8'd1);

   // A 1-cycle access completes on its accept edge, so it uses the live inputs.
   assign go_resp = fast || finish;
   assign go_wr   = fast ? write : op_wr;
   assign go_idx  = fast ? address[5+IDX_BITS-1:5] : lat_line[IDX_BITS-1:0];
   assign go_data = fast ? wdata : lat_data;
   assign go_tag  = fast ? in_tag : lat_tag;

   assign mism = op_wr ? (!write || read || wdata != lat_data)
                       : (!read || write);
   assign violate = (state != IDLE) && (mism || in_line != lat_line);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         op_wr     <= 1'b0;
         lat_line  <= 27'd0;
         lat_data  <= 256'd0;
         open_row  <= '0;
         row_valid <= 1'b0;
         resp      <= 1'b0;
         rdata     <= 256'd0;
         busy      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         resp <= 1'b0;
         if (clash || violate) proto_err <= 1'b1;
         if (go_resp) begin
            resp      <= 1'b1;
            open_row  <= go_tag;
            row_valid <= 1'b1;
            if (!go_wr) rdata <= mem[go_idx];
         end
         unique case (state)
            IDLE: begin
               if (accept) begin
                  op_wr    <= write;
                  lat_line <= in_line;
                  lat_data <= wdata;
                  busy     <= 1'b1;
                  cnt      <= lat - 8'd1;
                  state    <= fast ? RESP : BUSY;
               end
            end
            BUSY: begin
               if (finish) state <= RESP;
               else cnt <= cnt - 8'd1;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array is never reset; gating on reset keeps an aborted write out.
   always_ff @(posedge clk) begin
      if (go_resp && go_wr && !reset) mem[go_idx] <= go_data;
   end

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: transaction-level timeline model
// checked against the DUT every cycle, plus directed literal checks.
module tb_line_memory_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         read;
   logic         write;
   logic [31:0]  address;
   logic [255:0] wdata;
   logic         resp;
   logic [255:0] rdata;
   logic         busy;
   logic         proto_err;

   line_memory_responder dut (
      .clk(clk), .reset(reset), .read(read), .write(write),
      .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
      .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;
   int ecnt = 0;

   always @(posedge clk) ecnt++;

   // Model: memory image, open row, and the timeline of the one live access.
   bit [255:0] m_mem [4096];
   bit [255:0] m_rdata = '0;
   bit         m_rv = 0;
   bit [31:0]  m_row = 0;
   bit         m_act = 0;
   int         m_acc = 0;
   int         m_resp_edge = 0;
   bit         m_write = 0;
   int         m_idx = 0;
   bit [255:0] m_data = '0;
   bit [31:0]  m_tag = 0;
   int         err_edge = -1;

   task automatic chk(input string nm, input logic [255:0] got,
                      input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %h expected %h", nm, ecnt, got, exp);
      end
   endtask

   task automatic model_clear();
      m_act = 0;
      m_rv = 0;
      m_rdata = '0;
      err_edge = -1;
   endtask

   always @(negedge clk) begin
      bit e_resp, e_busy, e_err;
      if (m_act && ecnt == m_resp_edge) begin
         if (m_write) m_mem[m_idx] = m_data;
         else m_rdata = m_mem[m_idx];
         m_row = m_tag;
         m_rv = 1;
      end
      e_resp = m_act && ecnt == m_resp_edge;
      e_busy = m_act && ecnt >= m_acc && ecnt <= m_resp_edge;
      e_err  = err_edge >= 0 && ecnt >= err_edge;
      chk("resp", 256'(resp), 256'(e_resp));
      chk("busy", 256'(busy), 256'(e_busy));
      chk("proto_err", 256'(proto_err), 256'(e_err));
      chk("rdata", rdata, m_rdata);
   end

   // Called #1 after a rising edge with the DUT idle at the next edge.
   task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                      input int drop_k, input int rst_k,
                      output int lat, output int acc);
      int L, k;
      bit aborted;
      aborted = 0;
      read = !wr;
      write = wr;
      address = a;
      wdata = d;
      acc = ecnt + 1;
      L = (m_rv && (a >> 11) == m_row) ? 4 : 12;
      m_acc = acc;
      m_resp_edge = acc + L - 1;
      m_write = wr;
      m_idx = int'((a >> 5) & 32'hFFF);
      m_data = d;
      m_tag = a >> 11;
      m_act = 1;
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         k = ecnt - acc;
         if (rst_k > 0 && k == rst_k) begin
            reset = 1;
            model_clear();
            #1;
            chk("rst_busy_now", 256'(busy), 256'(0));
            chk("rst_resp_now", 256'(resp), 256'(0));
            @(posedge clk);
            #1;
            reset = 0;
            read = 0;
            write = 0;
            lat = 0;
            aborted = 1;
            break;
         end
         if (drop_k > 0 && k == drop_k) begin
            read = 0;
            write = 0;
            if (err_edge < 0) err_edge = ecnt + 1;
         end
         if (resp) begin
            lat = k + 1;
            break;
         end
      end
      if (!aborted) begin
         if (lat < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL resp_timeout: got no resp, required one at edge %0d", m_resp_edge);
         end
         @(posedge clk);
         #1;
         read = 0;
         write = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat, acc, prev_acc;
      logic [255:0] d1, dd, dr;
      logic [31:0] a;
      int tag, line;
      int tags [5];
      logic [31:0] t2_addr [4];
      int t2_lat [4];
      tags = '{0, 1, 2, 64, 65};
      t2_addr = '{32'h1000, 32'h1020, 32'h3000, 32'h1000};
      t2_lat = '{12, 4, 12, 12};
      reset = 1;
      read = 0;
      write = 0;
      address = 0;
      wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      chk("reset_resp", 256'(resp), 256'(0));
      chk("reset_busy", 256'(busy), 256'(0));
      chk("reset_err", 256'(proto_err), 256'(0));
      chk("reset_rdata", rdata, 256'(0));

      d1 = {8{32'hA5A5_0001}};
      txn(1, 32'h100, d1, 0, 0, lat, acc);
      chk("t1_wr_lat", 256'(lat), 256'(12));
      txn(0, 32'h100, '0, 0, 0, lat, acc);
      chk("t1_rd_lat", 256'(lat), 256'(4));
      chk("t1_rdata", rdata, {8{32'hA5A5_0001}});

      prev_acc = 0;
      for (int i = 0; i < 4; i++) begin
         txn(0, t2_addr[i], '0, 0, 0, lat, acc);
         chk($sformatf("t2_lat%0d", i), 256'(lat), 256'(t2_lat[i]));
         if (i > 0)
            chk($sformatf("t2_gap%0d", i), 256'(acc - prev_acc), 256'(t2_lat[i-1] + 1));
         prev_acc = acc;
      end

      for (int w = 0; w < 8; w++) dd[w*32 +: 32] = $urandom();
      txn(1, 32'h40, dd, 0, 0, lat, acc);
      chk("t3_wr_lat", 256'(lat), 256'(12));
      txn(0, 32'h5C, '0, 0, 0, lat, acc);
      chk("t3_off_lat", 256'(lat), 256'(4));
      chk("t3_off_rdata", rdata, dd);
      txn(0, 32'h0008_0040, '0, 0, 0, lat, acc);
      chk("t3_alias_lat", 256'(lat), 256'(12));
      chk("t3_alias_rdata", rdata, dd);

      for (int n = 0; n < 60; n++) begin
         tag = tags[$urandom_range(0, 4)];
         line = $urandom_range(0, 63);
         if ((tag == 0 || tag == 64) && line == 24) line = 25;
         a = (32'(tag) << 11) | (32'(line) << 5) | 32'($urandom_range(0, 31));
         for (int w = 0; w < 8; w++) dr[w*32 +: 32] = $urandom();
         txn(1'($urandom_range(0, 1)), a, dr, 0, 0, lat, acc);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      do_reset();
      read = 1;
      write = 1;
      err_edge = ecnt + 1;
      @(posedge clk);
      #1;
      chk("t4_err", 256'(proto_err), 256'(1));
      repeat (19) begin
         @(posedge clk);
         #1;
         chk("t4_busy", 256'(busy), 256'(0));
         chk("t4_resp", 256'(resp), 256'(0));
      end
      read = 0;
      write = 0;

      do_reset();
      txn(0, 32'h200, '0, 2, 0, lat, acc);
      chk("t5_lat", 256'(lat), 256'(12));
      chk("t5_err", 256'(proto_err), 256'(1));

      do_reset();
      txn(1, 32'h300, {256{1'b1}}, 0, 5, lat, acc);
      repeat (15) begin
         @(posedge clk);
         #1;
         chk("t6_no_resp", 256'(resp), 256'(0));
      end
      txn(0, 32'h300, '0, 0, 0, lat, acc);
      chk("t6_rd_lat", 256'(lat), 256'(12));
      chk("t6_rdata", rdata, 256'(0));
      chk("t6_err", 256'(proto_err), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
